// File: rtl/sw_ctrl_pkg.sv
// Shared types and constants for the stopwatch button control stage.
// This package holds the run-state encoding, the default debounce length and the button slot indices.
package sw_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 10000;

  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_CLEAR = 2;
  localparam int BTN_LAP   = 3;
  localparam int NUM_BTN   = 4;

endpackage

// File: rtl/sw_debounce.sv
// This module brings one raw button into the clock domain and debounces it.
// It takes a 2-FF synchroniser and then a stable-run counter, and outputs the accepted level.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int DB_CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_db
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                r_q1;
  logic                r_q2;
  logic                r_db;
  logic [DB_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1  <= 1'b0;
      r_q2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_q1 <= i_btn;
      r_q2 <= r_q1;
      // The accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (r_q2 != r_db) begin
        if (r_cnt == CNT_LAST) begin
          r_db  <= r_q2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DB_CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/sw_button_ctrl.sv
// This module turns debounced stopwatch buttons into one-cycle press pulses.
// A run-state FSM uses those pulses to drive the start/stop levels, the clear pulse and the lap freeze.
module sw_button_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DB_CNT_W        = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      ena,
  input  logic      btn_start,
  input  logic      btn_stop,
  input  logic      btn_clear,
  input  logic      btn_lap,
  output logic      start,
  output logic      stop,
  output logic      clear,
  output logic      lap_freeze,
  output logic      running,
  output sw_state_t dbg_state
);

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_db;
  logic [NUM_BTN-1:0] r_db_q;
  logic [NUM_BTN-1:0] w_press;

  sw_state_t r_state;
  sw_state_t w_state_nxt;
  logic      r_lap_freeze;
  logic      w_lap_nxt;
  logic      r_clear;
  logic      w_clear_nxt;

  assign w_btn_raw[BTN_START] = btn_start;
  assign w_btn_raw[BTN_STOP]  = btn_stop;
  assign w_btn_raw[BTN_CLEAR] = btn_clear;
  assign w_btn_raw[BTN_LAP]   = btn_lap;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
      sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_CNT_W       (DB_CNT_W)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .i_btn(w_btn_raw[gi]),
        .o_db (w_db[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_db_q <= '0;
    else        r_db_q <= w_db;
  end

  // Press pulses come from rising edges only. A press that rises while ena is low is gone for good.
  assign w_press = w_db & ~r_db_q & {NUM_BTN{ena}};

  // The highest-priority pulse present is the only candidate this cycle.
  // If that pulse has no meaning in the current state, nothing happens.
  always_comb begin
    w_state_nxt = r_state;
    w_lap_nxt   = r_lap_freeze;
    w_clear_nxt = 1'b0;
    if (w_press[BTN_STOP]) begin
      if (r_state == RUNNING) begin
        w_state_nxt = PAUSED;
        w_lap_nxt   = 1'b0;
      end
    end else if (w_press[BTN_START]) begin
      if (r_state == IDLE || r_state == PAUSED) w_state_nxt = RUNNING;
    end else if (w_press[BTN_CLEAR]) begin
      if (r_state == IDLE) begin
        w_clear_nxt = 1'b1;
      end else if (r_state == PAUSED) begin
        w_state_nxt = IDLE;
        w_clear_nxt = 1'b1;
      end
    end else if (w_press[BTN_LAP]) begin
      if (r_state == RUNNING)     w_lap_nxt = ~r_lap_freeze;
      else if (r_state == PAUSED) w_lap_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lap_freeze <= 1'b0;
      r_clear      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lap_freeze <= w_lap_nxt;
      r_clear      <= w_clear_nxt;
    end
  end

  assign start      = (r_state == RUNNING);
  assign stop       = (r_state == PAUSED);
  assign running    = start;
  assign clear      = r_clear;
  assign lap_freeze = r_lap_freeze;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_sw_button_ctrl.sv
// This is the self-checking bench for sw_button_ctrl, run with a short debounce of D=4.
// It applies a table of button presses and some hand-written timing sequences, and compares the outputs against expected values held in a queue.
module tb_sw_button_ctrl;
  import sw_ctrl_pkg::*;

  localparam int D = 4;
  localparam int W = 7;  // {start, stop, clear, lap_freeze, running, clear_pulses[1:0]}

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      ena = 1'b1;
  logic      btn_start = 1'b0;
  logic      btn_stop = 1'b0;
  logic      btn_clear = 1'b0;
  logic      btn_lap = 1'b0;
  logic      start, stop, clear, lap_freeze, running;
  sw_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int clr_total = 0;
  int c0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [3:0]   btn;   // {lap, clear, stop, start}
    int           hold;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[23];

  sw_button_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .DB_CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_clear (btn_clear),
    .btn_lap   (btn_lap),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .lap_freeze(lap_freeze),
    .running   (running),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clear === 1'b1) clr_total <= clr_total + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btn_lap, btn_clear, btn_stop, btn_start} = m;
  endtask

  task automatic do_reset();
    set_btns(4'b0000);
    ena   = 1'b1;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
  endtask

  function automatic logic [W-1:0] sample(input int base);
    return {start, stop, clear, lap_freeze, running, 2'(clr_total - base)};
  endfunction

  // scoreboard
  task automatic sb_check(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry, got %b", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", name, act, e);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0100, 6, 7'b0000001};  // clear in IDLE: one pulse
    vecs[1]  = '{4'b1000, 6, 7'b0000000};  // lap in IDLE ignored
    vecs[2]  = '{4'b0010, 6, 7'b0000000};  // stop in IDLE ignored
    vecs[3]  = '{4'b0001, 6, 7'b1000100};  // start -> RUNNING
    vecs[4]  = '{4'b0001, 6, 7'b1000100};  // start in RUNNING ignored
    vecs[5]  = '{4'b0100, 6, 7'b1000100};  // clear in RUNNING ignored
    vecs[6]  = '{4'b1000, 6, 7'b1001100};  // lap -> freeze 1
    vecs[7]  = '{4'b1000, 6, 7'b1000100};  // lap -> freeze 0
    vecs[8]  = '{4'b1000, 6, 7'b1001100};  // lap -> freeze 1
    vecs[9]  = '{4'b0010, 6, 7'b0100000};  // stop -> PAUSED, freeze 0
    vecs[10] = '{4'b1000, 6, 7'b0100000};  // lap in PAUSED keeps freeze 0
    vecs[11] = '{4'b0001, 6, 7'b1000100};  // resume
    vecs[12] = '{4'b1000, 6, 7'b1001100};  // lap -> freeze 1
    vecs[13] = '{4'b0011, 6, 7'b0100000};  // start+stop in RUNNING -> PAUSED
    vecs[14] = '{4'b0011, 6, 7'b0100000};  // start+stop in PAUSED -> stays
    vecs[15] = '{4'b1010, 6, 7'b0100000};  // stop+lap in PAUSED -> nothing
    vecs[16] = '{4'b0101, 6, 7'b1000100};  // start beats clear in PAUSED
    vecs[17] = '{4'b0010, 6, 7'b0100000};  // stop -> PAUSED
    vecs[18] = '{4'b0100, 6, 7'b0000001};  // clear in PAUSED -> IDLE + pulse
    vecs[19] = '{4'b0001, 3, 7'b0000000};  // D-1 cycle start rejected
    vecs[20] = '{4'b0001, 4, 7'b1000100};  // D cycle start accepted
    vecs[21] = '{4'b1100, 6, 7'b1000100};  // clear+lap in RUNNING: clear wins, ignored
    vecs[22] = '{4'b1000, 3, 7'b1000100};  // D-1 cycle lap rejected

    // reset state
    step(3);
    c0 = clr_total;
    exp_q.push_back(7'b0000000);
    sb_check("reset_outputs", sample(c0));
    rst_n = 1'b1;
    step(2);

    // start held from edge 0: RUNNING appears exactly after edge D+2
    c0 = clr_total;
    exp_q.push_back(7'b0000000);
    exp_q.push_back(7'b1000100);
    btn_start = 1'b1;
    step(D + 2);
    sb_check("start_edge5", sample(c0));
    step(1);
    sb_check("start_edge6", sample(c0));
    btn_start = 1'b0;
    step(12);

    // stop glitch of D-1 cycles rejected, then a D-cycle pulse accepted
    c0 = clr_total;
    exp_q.push_back(7'b1000100);
    btn_stop = 1'b1;
    step(D - 1);
    btn_stop = 1'b0;
    step(12);
    sb_check("stop_glitch", sample(c0));
    exp_q.push_back(7'b1000100);
    exp_q.push_back(7'b0100000);
    btn_stop = 1'b1;
    step(D);
    btn_stop = 1'b0;
    step(2);
    sb_check("stop_edge5", sample(c0));
    step(1);
    sb_check("stop_edge6", sample(c0));
    step(12);

    // clear from PAUSED: single-cycle pulse, then idle outputs
    c0 = clr_total;
    exp_q.push_back(7'b0100000);
    exp_q.push_back(7'b0010000);
    exp_q.push_back(7'b0000001);
    btn_clear = 1'b1;
    step(D + 2);
    sb_check("clear_edge5", sample(c0));
    step(1);
    sb_check("clear_edge6", sample(c0));
    step(1);
    sb_check("clear_edge7", sample(c0));
    btn_clear = 1'b0;
    step(12);

    // ena low across the press edge loses it, even when ena rises with the button held
    c0 = clr_total;
    exp_q.push_back(7'b0000000);
    ena = 1'b0;
    btn_start = 1'b1;
    step(10);
    ena = 1'b1;
    step(10);
    sb_check("ena_drop", sample(c0));
    btn_start = 1'b0;
    step(12);
    exp_q.push_back(7'b0000000);
    exp_q.push_back(7'b1000100);
    btn_start = 1'b1;
    step(D + 2);
    sb_check("ena_repress_edge5", sample(c0));
    step(1);
    sb_check("ena_repress_edge6", sample(c0));

    // async reset mid-RUNNING with start still held
    c0 = clr_total;
    exp_q.push_back(7'b0000000);
    #2 rst_n = 1'b0;
    #1 sb_check("async_reset_now", sample(c0));
    step(2);
    exp_q.push_back(7'b0000000);
    exp_q.push_back(7'b1000100);
    rst_n = 1'b1;
    step(D + 2);
    sb_check("post_reset_edge5", sample(c0));
    step(1);
    sb_check("post_reset_edge6", sample(c0));
    btn_start = 1'b0;
    step(12);

    // table-driven vectors from a fresh IDLE
    do_reset();
    for (int i = 0; i < 23; i++) begin
      c0 = clr_total;
      exp_q.push_back(vecs[i].exp);
      set_btns(vecs[i].btn);
      step(vecs[i].hold);
      set_btns(4'b0000);
      step(14);
      sb_check($sformatf("vec%0d", i), sample(c0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
